// File: rtl/bildpuffer_arbiter.sv
// Write-side controller for the frame buffer: shares the single write port
// between CPU pixel writes and a rectangle-fill engine, round-robin on contention.
module bildpuffer_arbiter #(
    parameter int WIDTH        = 160,
    parameter int HEIGHT       = 120,
    parameter int BITSPERPIXEL = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req,
    input  logic [7:0]              cpu_x,
    input  logic [7:0]              cpu_y,
    input  logic [BITSPERPIXEL-1:0] cpu_color,
    output logic                    cpu_ack,
    input  logic                    fill_start,
    input  logic [7:0]              fill_x0,
    input  logic [7:0]              fill_y0,
    input  logic [7:0]              fill_w,
    input  logic [7:0]              fill_h,
    input  logic [BITSPERPIXEL-1:0] fill_color,
    output logic                    fill_busy,
    output logic                    fill_done,
    output logic [7:0]              fb_x,
    output logic [7:0]              fb_y,
    output logic [BITSPERPIXEL-1:0] fb_color,
    output logic                    fb_write
);

    typedef enum logic {IDLE, FILL} state_t;
    typedef enum logic {GRANT_CPU, GRANT_FILL} grant_t;

    localparam logic [8:0] X_LIMIT = 9'(WIDTH);
    localparam logic [8:0] Y_LIMIT = 9'(HEIGHT);

    state_t                  state;
    state_t                  state_next;
    grant_t                  last_grant;

    logic [7:0]              x0;
    logic [7:0]              y0;
    logic [7:0]              w;
    logic [7:0]              h;
    logic [BITSPERPIXEL-1:0] color;
    logic [8:0]              cx;
    logic [8:0]              cy;

    logic                    cpu_pend;
    logic                    fill_pend;
    logic                    grant_cpu;
    logic                    grant_fill;
    logic [8:0]              x_last;
    logic [8:0]              y_last;
    logic                    row_end;
    logic                    last_pixel;
    logic                    pixel_visible;
    logic                    start_ok;
    logic                    start_zero;

    // Arbitration and fill-walk decode; the ack mask stops one request issuing twice
    always_comb begin
        cpu_pend      = cpu_req & ~cpu_ack;
        fill_pend     = (state == FILL);
        grant_cpu     = cpu_pend  & (~fill_pend | (last_grant == GRANT_FILL));
        grant_fill    = fill_pend & (~cpu_pend  | (last_grant == GRANT_CPU));
        x_last        = {1'b0, x0} + {1'b0, w} - 9'd1;
        y_last        = {1'b0, y0} + {1'b0, h} - 9'd1;
        row_end       = (cx == x_last);
        last_pixel    = row_end && (cy == y_last);
        pixel_visible = (cx < X_LIMIT) && (cy < Y_LIMIT);
        start_ok      = (state == IDLE) && fill_start && (fill_w != 8'd0) && (fill_h != 8'd0);
        start_zero    = (state == IDLE) && fill_start && ((fill_w == 8'd0) || (fill_h == 8'd0));
    end

    // Fill FSM next state: leave FILL once the final pixel has been granted
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = FILL;
            FILL:    if (grant_fill && last_pixel) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Fill FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Rectangle parameters latched at start, and the raster-order pixel cursor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0    <= '0;
            y0    <= '0;
            w     <= '0;
            h     <= '0;
            color <= '0;
            cx    <= '0;
            cy    <= '0;
        end else if (start_ok) begin
            x0    <= fill_x0;
            y0    <= fill_y0;
            w     <= fill_w;
            h     <= fill_h;
            color <= fill_color;
            cx    <= {1'b0, fill_x0};
            cy    <= {1'b0, fill_y0};
        end else if (grant_fill) begin
            if (row_end) begin
                cx <= {1'b0, x0};
                cy <= cy + 9'd1;
            end else begin
                cx <= cx + 9'd1;
            end
        end
    end

    // Round-robin memory: the CPU wins the first contention after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          last_grant <= GRANT_FILL;
        else if (grant_cpu)  last_grant <= GRANT_CPU;
        else if (grant_fill) last_grant <= GRANT_FILL;
    end

    // Registered frame-buffer port and handshake pulses; clipped fill pixels write nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_x      <= '0;
            fb_y      <= '0;
            fb_color  <= '0;
            fb_write  <= 1'b0;
            cpu_ack   <= 1'b0;
            fill_done <= 1'b0;
            fill_busy <= 1'b0;
        end else begin
            fb_write  <= 1'b0;
            cpu_ack   <= 1'b0;
            fill_done <= start_zero;
            fill_busy <= (state_next == FILL);
            if (grant_cpu) begin
                fb_x     <= cpu_x;
                fb_y     <= cpu_y;
                fb_color <= cpu_color;
                fb_write <= 1'b1;
                cpu_ack  <= 1'b1;
            end else if (grant_fill) begin
                if (pixel_visible) begin
                    fb_x     <= cx[7:0];
                    fb_y     <= cy[7:0];
                    fb_color <= color;
                    fb_write <= 1'b1;
                end
                if (last_pixel) fill_done <= 1'b1;
            end
        end
    end

endmodule
